fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequencing controller for the fetch stage. Drives PC stall, fetch/dispatch (IF/DP) latch stall and flush, and the change-of-flow select plus target address.
- Arbitrates three redirect sources (exception, branch mispredict, decode-stage jump) against dispatch back-pressure.
- Holds fetch quiet while the ROB performs misprediction/exception recovery.
- Maintains performance counters for redirects and stall cycles.

Parameters:
- MIN_RECOVER, 2, minimum cycles spent in RECOVER after a mispredict/exception redirect
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- excp_valid  in  1  exception redirect request from ROB commit
- excp_addr  in  32  exception handler address
- mispred_valid  in  1  branch mispredict from ROB/branch unit
- mispred_addr  in  32  corrected target
- jmp_valid  in  1  unconditional jump decoded in DP
- jmp_addr  in  32  jump target
- dp_stall  in  1  dispatch back-pressure (ROB/RS full, freelist empty)
- halt_DP  in  1  halt instruction in DP
- recover_done  in  1  ROB recovery walk complete
- changeFlow  out  1  PC loads jb_addr
- jb_addr  out  32  redirect target
- stall_PC  out  1  hold PC
- stall_IF_DP  out  1  hold IF/DP latch
- flush_IF_DP  out  1  zero IF/DP instruction
- halted  out  1  controller in HALT
- redirect_cnt  out  CNT_W  accepted redirects
- stall_cnt  out  CNT_W  cycles with stall_PC=1

Behaviour:
- Clock is clk. Reset is rst, asynchronous and active-low.
- States: RUN, RECOVER, HALT. Reset state is RUN.
- Reset values: recovery counter 0, both perf counters 0, every output 0.
- Outputs are combinational from state and inputs. State and counters update on posedge clk.
- Redirect priority: excp > mispred > jmp. Only the winner is used, and jb_addr is the winner's address. When there is no redirect, jb_addr=0.

RUN:
- excp or mispred:
  - changeFlow=1, flush_IF_DP=1, stall_PC=0. This overrides dp_stall.
  - Next state RECOVER; recovery counter loads MIN_RECOVER.
- jmp_valid && !dp_stall:
  - changeFlow=1, flush_IF_DP=1.
  - Stay in RUN. This is the 1-bubble jump path.
- jmp_valid && dp_stall: the jump is ignored. Decode holds it and re-presents it.
- dp_stall with no redirect: stall_PC=1, stall_IF_DP=1.
- halt_DP && !dp_stall with no redirect:
  - stall_PC=1, stall_IF_DP=1.
  - Next state HALT.

RECOVER:
- Outputs: stall_PC=1, flush_IF_DP=1, stall_IF_DP=0.
- Counter decrements, saturating at 0.
- Exit to RUN when counter==0 and recover_done=1. recover_done is sampled that cycle.
- First cycle in RUN: the PC (already holding the target) is fetched and latched normally.
- excp during RECOVER:
  - changeFlow=1 with excp_addr; stall_PC=0 for that cycle.
  - Counter reloads to MIN_RECOVER; stay in RECOVER.
- mispred during RECOVER: same as excp (an older branch).
- jmp and halt_DP are ignored during RECOVER.

HALT:
- Outputs: stall_PC=1, stall_IF_DP=1, halted=1.
- excp: redirect as in RUN, next state RECOVER.
- All other inputs are ignored. Exit only by excp or rst.

Counters:
- redirect_cnt increments on every cycle with changeFlow=1.
- stall_cnt increments on every cycle with stall_PC=1.
- Both wrap modulo 2^CNT_W.

Simultaneous and boundary events:
- excp and mispred in the same cycle: excp wins, one increment.
- recover_done arriving while counter>0: ignored unless it is still high when counter==0. The ROB holds it level until acknowledged by the RUN transition.
- Reset mid-RECOVER or mid-HALT: immediately RUN with all outputs 0.

Decomposition:
- Shared package `ooo_pkg`:
  - state enum (RUN=2'd0, RECOVER=2'd1, HALT=2'd2)
  - XLEN=32 constant
- Redirect priority mux as sub-module `redirect_arb`:
  - inputs: 3 valids and 3 addresses
  - outputs: sel_valid, sel_is_recover, sel_addr
  - purely combinational
- FSM and counters stay in `fetch_ctrl`.

Test Plan:
- Reset then idle 5 cycles -> all outputs 0, state RUN, stall_cnt=0.
- jmp_valid=1, jmp_addr=0x40 for one cycle, dp_stall=0 -> changeFlow=1, jb_addr=0x40, flush_IF_DP=1 that cycle, RUN next; redirect_cnt=1.
- mispred_valid=1, mispred_addr=0x80, recover_done at cycle +1 (MIN_RECOVER=2) -> redirect cycle, then stall_PC=flush_IF_DP=1 for exactly 2 cycles until counter==0 and done, then RUN; stall_cnt=2.
- excp (0x100), mispred (0x200) and jmp (0x300) in the same cycle -> jb_addr=0x100, redirect_cnt+1, enter RECOVER.
- dp_stall=1 with jmp_valid=1 for 3 cycles, then dp_stall=0 -> stall_PC=stall_IF_DP=1 for 3 cycles with changeFlow=0; redirect on the 4th cycle.
- halt_DP=1 -> HALT, halted=1 and stalls held 10 cycles; then excp 0x10 -> changeFlow, RECOVER; assert rst low mid-RECOVER -> immediate RUN, counters 0.

Source files
------------

// File: rtl/ooo_pkg.sv
// Shared types and constants for the out-of-order front end.
package ooo_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    RECOVER = 2'd1,
    HALT    = 2'd2
  } state_t;

endpackage

// File: rtl/redirect_arb.sv
// Redirect priority mux: exception > mispredict > jump.
// Inputs : excp/mispred/jmp valid + address
// Outputs: sel_valid (any redirect), sel_is_recover (excp or mispred),
//          sel_addr (winner's address, 0 when nothing is requested)
module redirect_arb
  import ooo_pkg::*;
(
  input  logic            excp_valid,
  input  logic [XLEN-1:0] excp_addr,
  input  logic            mispred_valid,
  input  logic [XLEN-1:0] mispred_addr,
  input  logic            jmp_valid,
  input  logic [XLEN-1:0] jmp_addr,
  output logic            sel_valid,
  output logic            sel_is_recover,
  output logic [XLEN-1:0] sel_addr
);

  always_comb begin
    sel_valid      = excp_valid | mispred_valid | jmp_valid;
    sel_is_recover = excp_valid | mispred_valid;
    sel_addr       = '0;
    if (excp_valid)         sel_addr = excp_addr;
    else if (mispred_valid) sel_addr = mispred_addr;
    else if (jmp_valid)     sel_addr = jmp_addr;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencing controller: PC / IF-DP stall and flush, change-of-flow
// select and target, recovery hold-off, and redirect / stall perf counters.
// Inputs : clk, rst (async active-low), redirect requests (excp, mispred, jmp),
//          dp_stall, halt_DP, recover_done
// Outputs: changeFlow, jb_addr, stall_PC, stall_IF_DP, flush_IF_DP, halted
//          (combinational from state + inputs), redirect_cnt, stall_cnt
module fetch_ctrl
  import ooo_pkg::*;
#(
  parameter int unsigned MIN_RECOVER = 2,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             excp_valid,
  input  logic [XLEN-1:0]  excp_addr,
  input  logic             mispred_valid,
  input  logic [XLEN-1:0]  mispred_addr,
  input  logic             jmp_valid,
  input  logic [XLEN-1:0]  jmp_addr,
  input  logic             dp_stall,
  input  logic             halt_DP,
  input  logic             recover_done,
  output logic             changeFlow,
  output logic [XLEN-1:0]  jb_addr,
  output logic             stall_PC,
  output logic             stall_IF_DP,
  output logic             flush_IF_DP,
  output logic             halted,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned RC_W = (MIN_RECOVER < 1) ? 1 : $clog2(MIN_RECOVER + 1);

  state_t          state, state_nxt;
  logic [RC_W-1:0] rcnt, rcnt_nxt, rcnt_dec;

  logic            sel_valid, sel_is_recover;
  logic [XLEN-1:0] sel_addr;

  redirect_arb u_arb (
    .excp_valid     (excp_valid),
    .excp_addr      (excp_addr),
    .mispred_valid  (mispred_valid),
    .mispred_addr   (mispred_addr),
    .jmp_valid      (jmp_valid),
    .jmp_addr       (jmp_addr),
    .sel_valid      (sel_valid),
    .sel_is_recover (sel_is_recover),
    .sel_addr       (sel_addr)
  );

  // State register and recovery counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      rcnt  <= '0;
    end else begin
      state <= state_nxt;
      rcnt  <= rcnt_nxt;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt   = state;
    rcnt_nxt    = rcnt;
    rcnt_dec    = (rcnt == '0) ? '0 : rcnt - RC_W'(1);
    changeFlow  = 1'b0;
    jb_addr     = '0;
    stall_PC    = 1'b0;
    stall_IF_DP = 1'b0;
    flush_IF_DP = 1'b0;
    halted      = 1'b0;

    unique case (state)
      RUN: begin
        if (sel_is_recover) begin
          // Recovery redirects win over back-pressure.
          changeFlow  = 1'b1;
          flush_IF_DP = 1'b1;
          state_nxt   = RECOVER;
          rcnt_nxt    = RC_W'(MIN_RECOVER);
        end else if (jmp_valid && !dp_stall) begin
          changeFlow  = 1'b1;
          flush_IF_DP = 1'b1;
        end else if (dp_stall) begin
          // A stalled jump is dropped; decode re-presents it.
          stall_PC    = 1'b1;
          stall_IF_DP = 1'b1;
        end else if (halt_DP) begin
          stall_PC    = 1'b1;
          stall_IF_DP = 1'b1;
          state_nxt   = HALT;
        end
      end

      RECOVER: begin
        flush_IF_DP = 1'b1;
        if (sel_is_recover) begin
          // Older branch or exception retargets and restarts the hold-off.
          changeFlow = 1'b1;
          rcnt_nxt   = RC_W'(MIN_RECOVER);
        end else begin
          stall_PC = 1'b1;
          rcnt_nxt = rcnt_dec;
          // Exit on the cycle the count reaches zero, so RECOVER spans
          // MIN_RECOVER cycles when the ROB is already done.
          if (rcnt_dec == '0 && recover_done) state_nxt = RUN;
        end
      end

      HALT: begin
        halted = 1'b1;
        if (excp_valid) begin
          changeFlow  = 1'b1;
          flush_IF_DP = 1'b1;
          state_nxt   = RECOVER;
          rcnt_nxt    = RC_W'(MIN_RECOVER);
        end else begin
          stall_PC    = 1'b1;
          stall_IF_DP = 1'b1;
        end
      end

      default: state_nxt = RUN;
    endcase

    if (changeFlow) jb_addr = sel_addr;

    // Outputs are quiet while reset is asserted, whatever the inputs do.
    if (!rst) begin
      changeFlow  = 1'b0;
      jb_addr     = '0;
      stall_PC    = 1'b0;
      stall_IF_DP = 1'b0;
      flush_IF_DP = 1'b0;
      halted      = 1'b0;
    end
  end

  // Performance counters, wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirect_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      redirect_cnt <= redirect_cnt + CNT_W'(changeFlow);
      stall_cnt    <= stall_cnt + CNT_W'(stall_PC);
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        excp_valid, mispred_valid, jmp_valid;
  logic [31:0] excp_addr, mispred_addr, jmp_addr;
  logic        dp_stall, halt_DP, recover_done;
  logic        changeFlow, stall_PC, stall_IF_DP, flush_IF_DP, halted;
  logic [31:0] jb_addr, redirect_cnt, stall_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.MIN_RECOVER(2), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .excp_valid(excp_valid), .excp_addr(excp_addr),
    .mispred_valid(mispred_valid), .mispred_addr(mispred_addr),
    .jmp_valid(jmp_valid), .jmp_addr(jmp_addr),
    .dp_stall(dp_stall), .halt_DP(halt_DP), .recover_done(recover_done),
    .changeFlow(changeFlow), .jb_addr(jb_addr), .stall_PC(stall_PC),
    .stall_IF_DP(stall_IF_DP), .flush_IF_DP(flush_IF_DP), .halted(halted),
    .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic        ex; logic [31:0] ea;
    logic        mp; logic [31:0] ma;
    logic        jv; logic [31:0] ja;
    logic        ds; logic hd; logic rd;
    logic        cf; logic [31:0] jb;
    logic        spc; logic sif; logic fl; logic hl;
    int          rc; int sc;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ex, input logic [31:0] ea, input logic mp, input logic [31:0] ma,
                       input logic jv, input logic [31:0] ja, input logic ds, input logic hd,
                       input logic rd);
    excp_valid = ex; excp_addr = ea; mispred_valid = mp; mispred_addr = ma;
    jmp_valid = jv; jmp_addr = ja; dp_stall = ds; halt_DP = hd; recover_done = rd;
  endtask

  task automatic chk_outs(input string tag, input logic cf, input logic [31:0] jb, input logic spc,
                          input logic sif, input logic fl, input logic hl);
    chk({tag, ".changeFlow"}, 32'(changeFlow), 32'(cf));
    chk({tag, ".jb_addr"}, jb_addr, jb);
    chk({tag, ".stall_PC"}, 32'(stall_PC), 32'(spc));
    chk({tag, ".stall_IF_DP"}, 32'(stall_IF_DP), 32'(sif));
    chk({tag, ".flush_IF_DP"}, 32'(flush_IF_DP), 32'(fl));
    chk({tag, ".halted"}, 32'(halted), 32'(hl));
  endtask

  // Drive, sample at negedge, then advance past the next posedge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //        ex ea      mp ma      jv ja      ds hd rd  cf jb      spc sif fl hl  rc sc
    vecs[0]  = '{0,0,     0,0,     1,32'h40, 0,0,0,  1,32'h40, 0,0,1,0, 0,0};
    vecs[1]  = '{0,0,     0,0,     0,0,      0,0,0,  0,0,      0,0,0,0, 1,0};
    vecs[2]  = '{0,0,     1,32'h80,0,0,      0,0,0,  1,32'h80, 0,0,1,0, 1,0};
    vecs[3]  = '{0,0,     0,0,     0,0,      0,0,1,  0,0,      1,0,1,0, 2,0};
    vecs[4]  = '{0,0,     0,0,     0,0,      0,0,1,  0,0,      1,0,1,0, 2,1};
    vecs[5]  = '{0,0,     0,0,     0,0,      0,0,0,  0,0,      0,0,0,0, 2,2};
    vecs[6]  = '{1,32'h100,1,32'h200,1,32'h300,0,0,0, 1,32'h100,0,0,1,0, 2,2};
    vecs[7]  = '{0,0,     0,0,     0,0,      0,0,0,  0,0,      1,0,1,0, 3,2};
    vecs[8]  = '{0,0,     0,0,     1,32'h300,0,1,0,  0,0,      1,0,1,0, 3,3};
    vecs[9]  = '{0,0,     1,32'h500,0,0,     0,0,0,  1,32'h500,0,0,1,0, 3,4};
    vecs[10] = '{0,0,     0,0,     0,0,      0,0,1,  0,0,      1,0,1,0, 4,4};
    vecs[11] = '{0,0,     0,0,     0,0,      0,0,1,  0,0,      1,0,1,0, 4,5};
    vecs[12] = '{0,0,     0,0,     1,32'h60, 1,0,0,  0,0,      1,1,0,0, 4,6};
    vecs[13] = '{0,0,     0,0,     1,32'h60, 1,0,0,  0,0,      1,1,0,0, 4,7};
    vecs[14] = '{0,0,     0,0,     1,32'h60, 1,0,0,  0,0,      1,1,0,0, 4,8};
    vecs[15] = '{0,0,     0,0,     1,32'h60, 0,0,0,  1,32'h60, 0,0,1,0, 4,9};
    vecs[16] = '{0,0,     1,32'h70,0,0,      1,0,0,  1,32'h70, 0,0,1,0, 5,9};
    vecs[17] = '{0,0,     0,0,     0,0,      0,0,1,  0,0,      1,0,1,0, 6,9};
    vecs[18] = '{0,0,     0,0,     0,0,      0,0,1,  0,0,      1,0,1,0, 6,10};
    vecs[19] = '{0,0,     0,0,     0,0,      1,1,0,  0,0,      1,1,0,0, 6,11};
    vecs[20] = '{0,0,     0,0,     0,0,      0,1,0,  0,0,      1,1,0,0, 6,12};

    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_outs($sformatf("idle%0d", i), 0, 0, 0, 0, 0, 0);
      next_cycle();
    end
    @(negedge clk);
    chk("idle.redirect_cnt", redirect_cnt, 32'd0);
    chk("idle.stall_cnt", stall_cnt, 32'd0);
    next_cycle();

    // Table-driven sequence: one vector per cycle, state carries across.
    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].ex, vecs[i].ea, vecs[i].mp, vecs[i].ma, vecs[i].jv, vecs[i].ja,
            vecs[i].ds, vecs[i].hd, vecs[i].rd);
      @(negedge clk);
      chk_outs($sformatf("v%0d", i), vecs[i].cf, vecs[i].jb, vecs[i].spc, vecs[i].sif,
               vecs[i].fl, vecs[i].hl);
      chk($sformatf("v%0d.redirect_cnt", i), redirect_cnt, 32'(vecs[i].rc));
      chk($sformatf("v%0d.stall_cnt", i), stall_cnt, 32'(vecs[i].sc));
      next_cycle();
    end

    // HALT ignores everything but excp for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, i[0], 32'h900, i[1], 32'h904, i[2], 1, 1);
      @(negedge clk);
      chk_outs($sformatf("halt%0d", i), 0, 0, 1, 1, 0, 1);
      next_cycle();
    end

    drive(1, 32'h10, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("halt_excp.changeFlow", 32'(changeFlow), 32'd1);
    chk("halt_excp.jb_addr", jb_addr, 32'h10);
    chk("halt_excp.flush_IF_DP", 32'(flush_IF_DP), 32'd1);
    chk("halt_excp.stall_PC", 32'(stall_PC), 32'd0);
    chk("halt_excp.redirect_cnt", redirect_cnt, 32'd6);
    chk("halt_excp.stall_cnt", stall_cnt, 32'd23);
    next_cycle();

    // First RECOVER cycle, then async reset mid-cycle.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk_outs("rec_pre_rst", 0, 0, 1, 0, 1, 0);
    chk("rec_pre_rst.redirect_cnt", redirect_cnt, 32'd7);
    #2 rst = 1'b0;
    #1;
    chk_outs("in_rst", 0, 0, 0, 0, 0, 0);
    chk("in_rst.redirect_cnt", redirect_cnt, 32'd0);
    chk("in_rst.stall_cnt", stall_cnt, 32'd0);
    next_cycle();
    rst = 1'b1;

    // Back in RUN: idle is quiet, a jump takes the bubble path.
    @(negedge clk);
    chk_outs("post_rst_idle", 0, 0, 0, 0, 0, 0);
    next_cycle();
    drive(0, 0, 0, 0, 1, 32'h44, 0, 0, 0);
    @(negedge clk);
    chk_outs("post_rst_jmp", 1, 32'h44, 0, 0, 1, 0);
    chk("post_rst_jmp.stall_cnt", stall_cnt, 32'd0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("post_rst.redirect_cnt", redirect_cnt, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
